// File: rtl/reg_file_direct_backend_if.sv
// Direct-access register file interface: per-register write lanes from the
// master, and all register contents returned combinationally by the slave.
interface ifc_reg_file_direct_access #(
  parameter int unsigned REGISTER_WIDTH = 32,
  parameter int unsigned NUM_REGISTERS  = 16
);
  logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] write_data;
  logic [NUM_REGISTERS-1:0]                     write_req;
  logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] read_data;

  modport master (
    output write_data,
    output write_req,
    input  read_data
  );

  modport slave (
    input  write_data,
    input  write_req,
    output read_data
  );
endinterface

// File: rtl/reg_file_direct_backend.sv
// Register-file backend: zero-latency direct-access port plus an addressed
// req/ack bus port with byte-strobed writes. The direct port wins any
// same-register write collision; the bus write retries until it is clear.
module reg_file_direct_backend #(
  parameter int unsigned REGISTER_WIDTH = 32,
  parameter int unsigned NUM_REGISTERS  = 16,
  parameter logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] RESET_VALUES = '0,
  parameter logic [NUM_REGISTERS-1:0] RO_MASK = '0,
  parameter int unsigned ADDR_W = $clog2(NUM_REGISTERS)
) (
  input  logic                        clk,
  input  logic                        rst,
  ifc_reg_file_direct_access.slave    reg_if,
  input  logic                        bus_req,
  input  logic                        bus_we,
  input  logic [ADDR_W-1:0]           bus_addr,
  input  logic [REGISTER_WIDTH-1:0]   bus_wdata,
  input  logic [REGISTER_WIDTH/8-1:0] bus_wstrb,
  output logic                        bus_ack,
  output logic                        bus_err,
  output logic [REGISTER_WIDTH-1:0]   bus_rdata,
  output logic [NUM_REGISTERS-1:0]    reg_updated
);

  localparam int unsigned NUM_BYTES = REGISTER_WIDTH / 8;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StResp = 1'b1;

  logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGISTERS-1:0]                     upd_q, upd_d;
  logic [0:0]                                   state_q, state_d;
  logic                                         err_q, err_d;
  logic [REGISTER_WIDTH-1:0]                    rdata_q, rdata_d;

  logic                      addr_ok;
  logic                      conflict;
  logic                      accept;
  logic                      bus_wr_commit;
  logic [REGISTER_WIDTH-1:0] sel_data;
  logic [REGISTER_WIDTH-1:0] byte_mask;

  assign reg_if.read_data = regs_q;

  // The range check only exists when the index space exceeds the register count.
  generate
    if ((1 << ADDR_W) > NUM_REGISTERS) begin : g_range
      assign addr_ok = (32'(bus_addr) < NUM_REGISTERS);
    end else begin : g_full
      assign addr_ok = 1'b1;
    end
  endgenerate

  // Select the addressed register and detect a competing direct write to it.
  always_comb begin
    sel_data = '0;
    conflict = 1'b0;
    for (int unsigned i = 0; i < NUM_REGISTERS; i++) begin
      if (bus_addr == ADDR_W'(i)) begin
        sel_data = regs_q[i];
        conflict = reg_if.write_req[i] & ~RO_MASK[i];
      end
    end
  end

  // Expand byte strobes into a per-bit write mask.
  always_comb begin
    byte_mask = '0;
    for (int unsigned b = 0; b < NUM_BYTES; b++) begin
      byte_mask[b*8 +: 8] = {8{bus_wstrb[b]}};
    end
  end

  // Out-of-range requests are always accepted; in-range writes wait out conflicts.
  assign accept        = (state_q == StIdle) & bus_req & ~(bus_we & addr_ok & conflict);
  assign bus_wr_commit = accept & bus_we & addr_ok;

  // Register next state: direct lanes, then a granted bus write (never the same lane).
  always_comb begin
    regs_d = regs_q;
    upd_d  = '0;
    for (int unsigned i = 0; i < NUM_REGISTERS; i++) begin
      if (reg_if.write_req[i] && !RO_MASK[i]) begin
        regs_d[i] = reg_if.write_data[i];
        upd_d[i]  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REGISTERS; i++) begin
      if (bus_wr_commit && (bus_addr == ADDR_W'(i))) begin
        regs_d[i] = (regs_q[i] & ~byte_mask) | (bus_wdata & byte_mask);
        upd_d[i]  = 1'b1;
      end
    end
  end

  // Bus FSM: capture the response on accept, present it for one cycle in RESP.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StResp;
          err_d   = ~addr_ok;
          // Read-before-write: sel_data is the pre-edge register value.
          rdata_d = (bus_we || !addr_ok) ? '0 : sel_data;
        end
      end
      StResp: begin
        state_d = StIdle;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q  <= RESET_VALUES;
      upd_q   <= '0;
      state_q <= StIdle;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      regs_q  <= regs_d;
      upd_q   <= upd_d;
      state_q <= state_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus_ack     = (state_q == StResp);
  assign bus_err     = err_q;
  assign bus_rdata   = rdata_q;
  assign reg_updated = upd_q;

endmodule

// File: tb/tb_reg_file_direct_backend.sv
// Bench for reg_file_direct_backend: two instances (16 registers with a
// read-only lane, and 12 registers for out-of-range addressing). Bus responses
// are checked by a scoreboard monitor; register state is checked directly.
module tb_reg_file_direct_backend;

  localparam logic [15:0][31:0] RV_A = {{12{32'h0}}, 32'hDEAD_BEEF, {3{32'h0}}};
  localparam logic [15:0]       RO_A = 16'h0002;
  localparam logic [11:0][31:0] RV_B = {32'h0BAD_F00D, {11{32'h0}}};

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  bit   clk = 1'b0;
  logic rst = 1'b0;

  logic        a_req, a_we, a_ack, a_err;
  logic [3:0]  a_addr, a_wstrb;
  logic [31:0] a_wdata, a_rdata;
  logic [15:0] a_upd;

  logic        b_req, b_we, b_ack, b_err;
  logic [3:0]  b_addr, b_wstrb;
  logic [31:0] b_wdata, b_rdata;
  logic [11:0] b_upd;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   upd_a[16];
  int   upd_b = 0;
  int   lat;

  ifc_reg_file_direct_access #(.REGISTER_WIDTH(32), .NUM_REGISTERS(16)) if_a ();
  ifc_reg_file_direct_access #(.REGISTER_WIDTH(32), .NUM_REGISTERS(12)) if_b ();

  reg_file_direct_backend #(
    .REGISTER_WIDTH(32), .NUM_REGISTERS(16), .RESET_VALUES(RV_A), .RO_MASK(RO_A)
  ) dut_a (
    .clk(clk), .rst(rst), .reg_if(if_a),
    .bus_req(a_req), .bus_we(a_we), .bus_addr(a_addr), .bus_wdata(a_wdata),
    .bus_wstrb(a_wstrb), .bus_ack(a_ack), .bus_err(a_err), .bus_rdata(a_rdata),
    .reg_updated(a_upd)
  );

  reg_file_direct_backend #(
    .REGISTER_WIDTH(32), .NUM_REGISTERS(12), .RESET_VALUES(RV_B), .RO_MASK(12'h000)
  ) dut_b (
    .clk(clk), .rst(rst), .reg_if(if_b),
    .bus_req(b_req), .bus_we(b_we), .bus_addr(b_addr), .bus_wdata(b_wdata),
    .bus_wstrb(b_wstrb), .bus_ack(b_ack), .bus_err(b_err), .bus_rdata(b_rdata),
    .reg_updated(b_upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one bus transaction, queue its expected response, wait (bounded) for ack.
  task automatic bus_xact(input bit sel, input bit we, input logic [3:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic [31:0] exp_rdata, input bit exp_err,
                          output int cycles);
    exp_t e;
    bit   got;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    if (sel) begin
      q_b.push_back(e);
      b_we = we; b_addr = addr; b_wdata = wdata; b_wstrb = wstrb; b_req = 1'b1;
    end else begin
      q_a.push_back(e);
      a_we = we; a_addr = addr; a_wdata = wdata; a_wstrb = wstrb; a_req = 1'b1;
    end
    got    = 1'b0;
    cycles = 0;
    while (!got && cycles < 20) begin
      @(negedge clk);
      cycles++;
      got = sel ? b_ack : a_ack;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL bus_timeout: no ack after %0d cycles, expected one", cycles);
      if (sel) void'(q_b.pop_back());
      else void'(q_a.pop_back());
    end
    if (sel) b_req = 1'b0;
    else a_req = 1'b0;
  endtask

  // Scoreboard monitor and update-pulse counters.
  always @(negedge clk) begin
    if (a_ack) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_ack: got ack, expected none");
      end else begin : pop_a
        exp_t e;
        e = q_a.pop_front();
        check("a_rdata", a_rdata, e.rdata);
        check("a_err", 32'(a_err), 32'(e.err));
      end
    end
    if (b_ack) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_ack: got ack, expected none");
      end else begin : pop_b
        exp_t e;
        e = q_b.pop_front();
        check("b_rdata", b_rdata, e.rdata);
        check("b_err", 32'(b_err), 32'(e.err));
      end
    end
    for (int i = 0; i < 16; i++) if (a_upd[i]) upd_a[i]++;
    for (int i = 0; i < 12; i++) if (b_upd[i]) upd_b++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) upd_a[i] = 0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_wstrb = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_wstrb = 0;
    if_a.write_req = '0; if_a.write_data = '0;
    if_b.write_req = '0; if_b.write_data = '0;

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("async_rd3", if_a.read_data[3], 32'hDEAD_BEEF);
    check("rst_ack", 32'(a_ack), 32'h0);
    check("rst_err", 32'(a_err), 32'h0);
    check("rst_rdata", a_rdata, 32'h0);
    check("rst_upd", 32'(a_upd), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rd3", if_a.read_data[3], 32'hDEAD_BEEF);
    check("rst_b_ack", 32'(b_ack), 32'h0);
    rst = 1'b0;
    tick();

    // Bus read of reset value, minimum latency.
    bus_xact(0, 0, 4'd3, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, lat);
    check("rd3_lat", lat, 2);
    tick();

    // Simultaneous direct write and bus read of register 5: read sees old value.
    if_a.write_data[5] = 32'h1234_5678;
    if_a.write_req[5]  = 1'b1;
    fork
      bus_xact(0, 0, 4'd5, 32'h0, 4'h0, 32'h0, 0, lat);
      begin
        @(posedge clk);
        #1 if_a.write_req[5] = 1'b0;
      end
    join
    check("rbw_rd5", if_a.read_data[5], 32'h1234_5678);
    check("rbw_upd5", 32'(a_upd[5]), 32'h1);
    tick();

    // Strobed bus write.
    bus_xact(0, 1, 4'd2, 32'hAABB_CCDD, 4'b0101, 32'h0, 0, lat);
    check("wr2_lat", lat, 2);
    tick();
    check("wr2_val", if_a.read_data[2], 32'h00BB_00DD);
    check("wr2_upd", upd_a[2], 1);
    bus_xact(0, 0, 4'd2, 32'h0, 4'h0, 32'h00BB_00DD, 0, lat);
    tick();

    // Bus write stalled by three cycles of direct writes to the same register.
    if_a.write_data[7] = 32'h1;
    if_a.write_req[7]  = 1'b1;
    fork
      bus_xact(0, 1, 4'd7, 32'hCAFE_0007, 4'hF, 32'h0, 0, lat);
      begin
        repeat (3) @(posedge clk);
        #1 if_a.write_req[7] = 1'b0;
      end
    join
    check("conf_lat", lat, 5);
    tick();
    check("conf_val", if_a.read_data[7], 32'hCAFE_0007);
    check("conf_upd", upd_a[7], 4);

    // Read-only lane drops direct writes but accepts bus writes.
    if_a.write_data[1] = 32'hFFFF_FFFF;
    if_a.write_req[1]  = 1'b1;
    tick();
    if_a.write_req[1] = 1'b0;
    check("ro_val", if_a.read_data[1], 32'h0);
    tick();
    check("ro_upd", upd_a[1], 0);
    bus_xact(0, 1, 4'd1, 32'h5, 4'hF, 32'h0, 0, lat);
    tick();
    check("ro_bus_val", if_a.read_data[1], 32'h5);
    check("ro_bus_upd", upd_a[1], 1);

    // Zero-strobe write: no data change, still pulses.
    bus_xact(0, 1, 4'd9, 32'hFFFF_FFFF, 4'h0, 32'h0, 0, lat);
    tick();
    check("wstrb0_val", if_a.read_data[9], 32'h0);
    check("wstrb0_upd", upd_a[9], 1);

    // Two direct lanes in one cycle.
    if_a.write_data[10] = 32'h10;
    if_a.write_data[11] = 32'h11;
    if_a.write_req[10]  = 1'b1;
    if_a.write_req[11]  = 1'b1;
    tick();
    if_a.write_req[10] = 1'b0;
    if_a.write_req[11] = 1'b0;
    check("multi_10", if_a.read_data[10], 32'h10);
    check("multi_11", if_a.read_data[11], 32'h11);
    tick();
    check("multi_upd", upd_a[10] + upd_a[11], 2);

    // Twelve-register instance: last valid address, then out-of-range accesses.
    bus_xact(1, 0, 4'd11, 32'h0, 4'h0, 32'h0BAD_F00D, 0, lat);
    tick();
    bus_xact(1, 0, 4'd12, 32'h0, 4'h0, 32'h0, 1, lat);
    tick();
    bus_xact(1, 0, 4'd13, 32'h0, 4'h0, 32'h0, 1, lat);
    tick();
    bus_xact(1, 1, 4'd13, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, lat);
    tick();
    for (int i = 0; i < 12; i++) check("oor_regs", if_b.read_data[i], RV_B[i]);
    check("oor_upd", upd_b, 0);

    // Reset during a conflict stall: transaction dropped, no ack.
    if_a.write_data[4] = 32'h4;
    if_a.write_req[4]  = 1'b1;
    a_we = 1'b1; a_addr = 4'd4; a_wdata = 32'h44; a_wstrb = 4'hF; a_req = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    a_req = 1'b0;
    if_a.write_req[4] = 1'b0;
    #1;
    check("rst_stall_rd4", if_a.read_data[4], 32'h0);
    check("rst_stall_rd7", if_a.read_data[7], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_stall_ack", 32'(a_ack), 32'h0);
    end
    check("rst_stall_rd3", if_a.read_data[3], 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_direct_backend.md
# reg_file_direct_backend

Register-file backend implementing the slave end of `ifc_reg_file_direct_access`. It holds `NUM_REGISTERS` registers, applies per-register writes from the direct-access master, and drives all `read_data` lanes with zero read latency. A second, addressed req/ack port gives software-side access: single-register read and byte-strobed write. The module arbitrates between the two ports and flags every committed write.

## Interface
- `REGISTER_WIDTH`, 32: bits per register; must be a multiple of 8.
- `NUM_REGISTERS`, 16: register count, at least 2.
- `RESET_VALUES`, all zero: packed `[NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0]` reset contents.
- `RO_MASK`, all zero: `[NUM_REGISTERS-1:0]`; a set bit makes that register read-only from the direct port. Bus writes to it still commit.
- `ADDR_W`, derived: `$clog2(NUM_REGISTERS)`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `reg_if`  `ifc_reg_file_direct_access.slave`: direct port (`write_data`, `write_req`, `read_data`).
- `bus_req`  in  1  request; held high until `bus_ack`.
- `bus_we`  in  1  1 = write, 0 = read.
- `bus_addr`  in  ADDR_W  register index.
- `bus_wdata`  in  REGISTER_WIDTH  write data.
- `bus_wstrb`  in  REGISTER_WIDTH/8  byte enables.
- `bus_ack`  out  1  one-cycle completion pulse.
- `bus_err`  out  1  valid with `bus_ack`; 1 = address out of range.
- `bus_rdata`  out  REGISTER_WIDTH  read data, valid with `bus_ack`.
- `reg_updated`  out  NUM_REGISTERS  per-register one-cycle pulse on a committed write.

## Operation
- Storage `regs[i]`. `read_data[i] = regs[i]` combinationally, for all i, at all times.
- Direct write: when `write_req[i]` = 1 and `RO_MASK[i]` = 0, `regs[i] <= write_data[i]` at that edge.
  - When `RO_MASK[i]` = 1, the write is dropped silently and no `reg_updated` pulse is generated.
  - Several lanes may be written in the same cycle.
- Bus FSM, states IDLE and RESP:
  - IDLE with `bus_req` = 0: stay in IDLE.
  - IDLE with `bus_req` = 1 and `bus_addr >= NUM_REGISTERS`: go to RESP with err = 1, rdata = 0, no write.
  - IDLE with `bus_req` = 1, read: capture `regs[bus_addr]` into `bus_rdata`, go to RESP.
  - IDLE with `bus_req` = 1, write, no conflict: apply the write and go to RESP with rdata = 0.
    - Write rule: byte b of `regs[bus_addr]` takes byte b of `bus_wdata` where `bus_wstrb[b]` = 1; all other bytes hold.
  - IDLE with `bus_req` = 1, write, conflict: stay in IDLE and retry next cycle.
    - Conflict means `write_req[bus_addr]` = 1 and `RO_MASK[bus_addr]` = 0 in the same cycle; the direct port has priority.
  - RESP: `bus_ack` = 1 for exactly one cycle, then return to IDLE. `bus_req` is ignored while in RESP.
- Requester protocol:
  - `bus_addr`, `bus_we`, `bus_wdata` and `bus_wstrb` stay stable while `bus_req` is high and ack has not yet arrived.
  - The requester drops `bus_req`, or presents a new request, after the ack cycle.
- Starvation: the direct master can stall bus writes indefinitely; bounding this is the system's responsibility. Bus reads never stall.
- `reg_updated[i]`: registered pulse, high in the cycle after any committed write to register i, from either port.
  - A bus write with `bus_wstrb` = 0 still counts as committed and pulses.

## Timing
- Reset (async assert, synchronous-release environment):
  - `regs` = `RESET_VALUES`, FSM in IDLE.
  - `bus_ack`, `bus_err`, `bus_rdata` and `reg_updated` all 0.
  - `read_data` reflects `RESET_VALUES` immediately.
- Direct write latency: `write_req` sampled at edge N; `read_data` shows the new value after edge N.
- Bus latency: request accepted at edge N; `bus_ack` is high from edge N until edge N+1. Minimum 1 cycle; each conflict cycle adds 1.
- Bus read returns the register value before any same-edge direct write (read-before-write).
- Back-to-back bus transactions: at best one every 2 cycles.
- Reset during RESP or during a conflict stall: the transaction is dropped, no ack is issued, and the FSM restarts in IDLE.

## Test plan
- Reset with `RESET_VALUES[3]` = 32'hDEAD_BEEF:
  - During reset, `read_data[3]` = DEADBEEF and all bus outputs are 0.
  - After release, a bus read of address 3 returns DEADBEEF with err = 0.
- Direct write 32'h1234_5678 to register 5 at edge N, simultaneous with a bus read of register 5:
  - The bus read returns the old value.
  - `read_data[5]` = 12345678 after edge N.
  - `reg_updated[5]` pulses in cycle N+1.
- Bus write of 32'hAABB_CCDD to register 2 with wstrb = 4'b0101, old value 0 → register 2 reads 32'h00BB_00DD and `reg_updated[2]` pulses.
- Bus write to register 7 while `write_req[7]` is held high for 3 cycles with data 32'h1:
  - `bus_ack` is delayed by 3 cycles.
  - Final value is the bus data.
  - `reg_updated[7]` pulses for all 4 writes (3 direct, 1 bus).
- `RO_MASK[1]` = 1, then a direct write of 32'hFFFF_FFFF to register 1 → value is unchanged and no update pulse; a subsequent bus write of 32'h5 commits.
- With `NUM_REGISTERS` = 12, bus access to address 13 → ack with err = 1, rdata = 0, and no register changes.
